line_cache: RTL and testbench
=============================

# line_cache

Direct-mapped, multi-word-line instruction/data cache between a core's load/store port and the memory bus. Read hits complete combinationally in the request cycle. Read misses stall the core while a finite-state machine refills the whole line one word per beat. Writes are write-through, no-write-allocate. A synchronous invalidate clears the whole cache.

## Interface
- `INDEX_BITS`, default 6: number of lines is 1 << INDEX_BITS.
- `WORD_BITS`, default 2: words per line is 1 << WORD_BITS.
- `clock` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_read_enable` in 1: read request. Held stable while `cpu_stall` is high.
- `cpu_write_enable` in 1: write request. Held stable while `cpu_stall` is high.
- `cpu_address` in regval_t: byte address. Bits [1:0] are ignored.
- `cpu_write_data` in regval_t: store data.
- `invalidate` in 1: single-cycle pulse that clears all valid bits.
- `cpu_read_valid` out 1: `cpu_read_data` is valid this cycle.
- `cpu_read_data` out regval_t: read result.
- `cpu_stall` out 1: the core must hold its request.
- `mem_address_enable` out 1: refill read request.
- `mem_address` out regval_t: refill word address, or write address.
- `mem_data_valid` in 1: `mem_data` carries the current refill beat.
- `mem_data` in regval_t: refill data.
- `mem_write_enable` out 1: write-through request.
- `mem_write_data` out regval_t: write-through data.
- `mem_write_ready` in 1: memory accepts the write this cycle.

## Operation
- **Address split:**
  - word = addr[WORD_BITS+1:2]
  - index = addr[INDEX_BITS+WORD_BITS+1:WORD_BITS+2]
  - tag = the remaining upper bits; width 32-INDEX_BITS-WORD_BITS-2.
- **State per line:** valid bit, tag, and 1<<WORD_BITS data words.
- **FSM states:** IDLE and FILL.
- **IDLE, read, hit** (valid and tag equal):
  - `cpu_read_valid`=1.
  - `cpu_read_data`=stored word.
  - `cpu_stall`=0.
- **IDLE, read, miss:**
  - `cpu_stall`=1.
  - Latch the line base (addr with word and byte bits zeroed).
  - Clear `beat`.
  - Go to FILL.
- **FILL:**
  - `mem_address_enable`=1.
  - `mem_address`=base + 4*beat.
  - `cpu_stall`=1.
  - On `mem_data_valid`, write `mem_data` to word `beat` and increment `beat`.
  - On the last beat, write the tag, set valid, and return to IDLE.
- **Write** (IDLE only):
  - `mem_write_enable`=1, `mem_address`=`cpu_address`, `mem_write_data`=`cpu_write_data`.
  - `cpu_stall`=!`mem_write_ready`.
  - In the accept cycle, on a hit, the cached word is also updated at the clock edge.
  - On a miss, the cache is unchanged.
- **Simultaneous read and write enable:** the write is serviced and the read is ignored. Protocol violation, flagged by an assertion.
- **Invalidate in IDLE:** all valid bits clear at the next edge. A hit in the same cycle still returns data.
- **Invalidate during FILL:**
  - It is latched as pending.
  - At fill completion the line is written but its valid bit is left 0, and all valid bits clear.
  - The held request then misses again.
- **Reset:**
  - Asynchronous, at any time including mid-FILL.
  - State becomes IDLE, all valid bits and `beat` clear, pending invalidate clears.
  - Data and tag arrays need no reset.
  - While `reset_n` is low all outputs are 0.

## Timing
- Read hit: 0-cycle latency, combinational.
- Read miss: `cpu_stall` is high from the request cycle through the last-beat cycle. The data is returned as a hit in the following IDLE cycle. Minimum miss cost is (1<<WORD_BITS)+1 cycles.
- Refill beats may be non-consecutive. `mem_address` advances only after an accepted beat.
- Write: completes in the `mem_write_ready` cycle. There is no write buffer.
- `beat` wraps to 0 on completion. Line base addresses never cross a line boundary.

## Structure
- **Shared types package:** already holds regval_t. Add the `line_cache_state_t` enum (IDLE, FILL).
- **Tag-width constant:** a localparam derived in-module from the parameters.
- **Sub-module `line_cache_store`:**
  - Holds the valid/tag/data arrays with one read port and one write port.
  - Provides a single-cycle clear-all of the valid bits.
- **`line_cache`:** holds the FSM, the beat counter and the output muxing.

## Test plan
All scenarios use INDEX_BITS=2 and WORD_BITS=2.
1. **Cold read miss:** read 0x104 after reset -> `mem_address` 0x100, 0x104, 0x108, 0x10C in order; then a hit returns the 0x104 word; `cpu_stall` is high for exactly 5 cycles with back-to-back beats.
2. **Hit / conflict:** read 0x108 after scenario 1 -> 0-cycle hit with no mem activity; then read 0x140 (same index, different tag) -> refill 0x140..0x14C; then read 0x100 misses again.
3. **Write-through:**
   - Write 0xDEADBEEF to 0x104 on a cached line with `mem_write_ready` delayed 3 cycles -> stall for 3 cycles, one mem write, and the subsequent read returns 0xDEADBEEF with no refill.
   - Write to an uncached line -> no refill.
4. **Invalidate:**
   - Pulse in IDLE -> the next read of 0x100 misses.
   - Pulse during beat 2 of a fill -> the fill completes, the held read refills again, and the data is correct.
5. **Beat gaps:** `mem_data_valid` held low 2 cycles between beats -> `mem_address` holds each address until its beat is accepted; final data correct.
6. **Reset mid-fill:** assert `reset_n` low after beat 1 -> `mem_address_enable` drops immediately; after release, a read of the same address is a miss with a full refill.

Source files
------------

// File: rtl/line_cache_pkg.sv
// Shared types for the line cache: the core register value and the refill FSM state.
package line_cache_pkg;

  typedef logic [31:0] regval_t;

  typedef enum logic {
    IDLE,
    FILL
  } line_cache_state_t;

endpackage

// File: rtl/line_cache_store.sv
// Valid/tag/data arrays for the direct-mapped cache.
// Provides one combinational read port, one write port, and a clear-all of the valid bits.
module line_cache_store
  import line_cache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int WORD_BITS  = 2,
  parameter int TAG_BITS   = 32 - INDEX_BITS - WORD_BITS - 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [INDEX_BITS-1:0] read_index,
  input  logic [WORD_BITS-1:0]  read_word,
  output logic                  read_line_valid,
  output logic [TAG_BITS-1:0]   read_tag,
  output regval_t               read_data,
  input  logic                  data_write,
  input  logic [INDEX_BITS-1:0] write_index,
  input  logic [WORD_BITS-1:0]  write_word,
  input  regval_t               write_data,
  input  logic                  tag_write,
  input  logic [TAG_BITS-1:0]   write_tag,
  input  logic                  valid_set,
  input  logic                  clear_all
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << WORD_BITS;

  logic [LINES-1:0]    valid_bits;
  logic [TAG_BITS-1:0] tags [LINES];
  regval_t             data [LINES][WORDS];

  // Clear-all wins over a line update so an invalidate during a refill leaves the line invalid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_bits <= '0;
    end else if (clear_all) begin
      valid_bits <= '0;
    end else if (tag_write) begin
      valid_bits[write_index] <= valid_set;
    end
  end

  always_ff @(posedge clock) begin
    if (data_write) begin
      data[write_index][write_word] <= write_data;
    end
    if (tag_write) begin
      tags[write_index] <= write_tag;
    end
  end

  assign read_line_valid = valid_bits[read_index];
  assign read_tag        = tags[read_index];
  assign read_data       = data[read_index][read_word];

endmodule

// File: rtl/line_cache.sv
// Direct-mapped write-through cache: combinational read hits, stalled line refill,
// no-write-allocate stores and a whole-cache invalidate.
module line_cache
  import line_cache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int WORD_BITS  = 2
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    cpu_read_enable,
  input  logic    cpu_write_enable,
  input  regval_t cpu_address,
  input  regval_t cpu_write_data,
  input  logic    invalidate,
  output logic    cpu_read_valid,
  output regval_t cpu_read_data,
  output logic    cpu_stall,
  output logic    mem_address_enable,
  output regval_t mem_address,
  input  logic    mem_data_valid,
  input  regval_t mem_data,
  output logic    mem_write_enable,
  output regval_t mem_write_data,
  input  logic    mem_write_ready
);

  localparam int OFFSET_BITS = WORD_BITS + 2;
  localparam int TAG_BITS    = 32 - INDEX_BITS - WORD_BITS - 2;
  localparam int LINE_BITS   = 32 - OFFSET_BITS;

  line_cache_state_t state, state_next;
  logic [WORD_BITS-1:0] beat, beat_next;
  logic [LINE_BITS-1:0] base_line, base_line_next;
  logic pending, pending_next;

  logic [WORD_BITS-1:0]  word_sel;
  logic [INDEX_BITS-1:0] index_sel;
  logic [TAG_BITS-1:0]   tag_sel;
  logic [INDEX_BITS-1:0] base_index;
  logic [TAG_BITS-1:0]   base_tag;

  logic                  read_line_valid;
  logic [TAG_BITS-1:0]   read_tag;
  regval_t               read_data;
  logic                  hit;

  logic                  data_write;
  logic [INDEX_BITS-1:0] write_index;
  logic [WORD_BITS-1:0]  write_word;
  regval_t               write_data;
  logic                  tag_write;
  logic                  valid_set;
  logic                  clear_all;

  assign word_sel   = cpu_address[OFFSET_BITS-1:2];
  assign index_sel  = cpu_address[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign tag_sel    = cpu_address[31:INDEX_BITS+OFFSET_BITS];
  assign base_index = base_line[INDEX_BITS-1:0];
  assign base_tag   = base_line[LINE_BITS-1:INDEX_BITS];
  assign hit        = read_line_valid && (read_tag == tag_sel);

  line_cache_store #(
    .INDEX_BITS(INDEX_BITS),
    .WORD_BITS (WORD_BITS),
    .TAG_BITS  (TAG_BITS)
  ) store (
    .clock          (clock),
    .reset_n        (reset_n),
    .read_index     (index_sel),
    .read_word      (word_sel),
    .read_line_valid(read_line_valid),
    .read_tag       (read_tag),
    .read_data      (read_data),
    .data_write     (data_write),
    .write_index    (write_index),
    .write_word     (write_word),
    .write_data     (write_data),
    .tag_write      (tag_write),
    .write_tag      (base_tag),
    .valid_set      (valid_set),
    .clear_all      (clear_all)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      beat      <= '0;
      base_line <= '0;
      pending   <= 1'b0;
    end else begin
      state     <= state_next;
      beat      <= beat_next;
      base_line <= base_line_next;
      pending   <= pending_next;
    end
  end

  // The store's write port is shared: refill beats in FILL, write-through hits in IDLE.
  always_comb begin
    state_next         = state;
    beat_next          = beat;
    base_line_next     = base_line;
    pending_next       = pending;
    cpu_read_valid     = 1'b0;
    cpu_read_data      = '0;
    cpu_stall          = 1'b0;
    mem_address_enable = 1'b0;
    mem_address        = '0;
    mem_write_enable   = 1'b0;
    mem_write_data     = '0;
    data_write         = 1'b0;
    write_index        = base_index;
    write_word         = beat;
    write_data         = mem_data;
    tag_write          = 1'b0;
    valid_set          = 1'b0;
    clear_all          = 1'b0;

    case (state)
      IDLE: begin
        pending_next = 1'b0;
        clear_all    = invalidate;
        if (cpu_write_enable) begin
          mem_write_enable = 1'b1;
          mem_address      = cpu_address;
          mem_write_data   = cpu_write_data;
          cpu_stall        = !mem_write_ready;
          if (mem_write_ready && hit) begin
            data_write  = 1'b1;
            write_index = index_sel;
            write_word  = word_sel;
            write_data  = cpu_write_data;
          end
        end else if (cpu_read_enable) begin
          if (hit) begin
            cpu_read_valid = 1'b1;
            cpu_read_data  = read_data;
          end else begin
            cpu_stall      = 1'b1;
            base_line_next = cpu_address[31:OFFSET_BITS];
            beat_next      = '0;
            state_next     = FILL;
          end
        end
      end

      FILL: begin
        mem_address_enable = 1'b1;
        mem_address        = {base_line, beat, 2'b00};
        cpu_stall          = 1'b1;
        pending_next       = pending || invalidate;
        if (mem_data_valid) begin
          data_write = 1'b1;
          beat_next  = beat + WORD_BITS'(1);
          if (beat == '1) begin
            tag_write    = 1'b1;
            valid_set    = !(pending || invalidate);
            clear_all    = pending || invalidate;
            pending_next = 1'b0;
            state_next   = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    if (!reset_n) begin
      cpu_read_valid     = 1'b0;
      cpu_read_data      = '0;
      cpu_stall          = 1'b0;
      mem_address_enable = 1'b0;
      mem_address        = '0;
      mem_write_enable   = 1'b0;
      mem_write_data     = '0;
    end
  end

  read_write_exclusive: assert property (
    @(posedge clock) disable iff (!reset_n) !(cpu_read_enable && cpu_write_enable)
  );

endmodule

// File: tb/tb_line_cache.sv
// Directed bench for line_cache with 4 lines of 4 words: a vector table for hits and
// single-cycle writes, plus hand-written refill, write-stall, invalidate and reset sequences.
module tb_line_cache;
  import line_cache_pkg::*;

  logic    clock = 1'b0;
  logic    reset_n;
  logic    cpu_read_enable, cpu_write_enable, invalidate;
  regval_t cpu_address, cpu_write_data;
  logic    cpu_read_valid, cpu_stall;
  regval_t cpu_read_data;
  logic    mem_address_enable, mem_data_valid, mem_write_enable, mem_write_ready;
  regval_t mem_address, mem_data, mem_write_data;

  regval_t mem_model [256];
  int      mem_writes = 0;
  int      assertions = 0;
  int      failures   = 0;

  typedef struct {
    logic    rd;
    logic    wr;
    regval_t addr;
    regval_t wdata;
    logic    exp_valid;
    regval_t exp_data;
    logic    exp_stall;
    logic    exp_mem_en;
    logic    exp_wen;
  } vec_t;

  vec_t vecs [7];

  line_cache #(.INDEX_BITS(2), .WORD_BITS(2)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .cpu_read_enable   (cpu_read_enable),
    .cpu_write_enable  (cpu_write_enable),
    .cpu_address       (cpu_address),
    .cpu_write_data    (cpu_write_data),
    .invalidate        (invalidate),
    .cpu_read_valid    (cpu_read_valid),
    .cpu_read_data     (cpu_read_data),
    .cpu_stall         (cpu_stall),
    .mem_address_enable(mem_address_enable),
    .mem_address       (mem_address),
    .mem_data_valid    (mem_data_valid),
    .mem_data          (mem_data),
    .mem_write_enable  (mem_write_enable),
    .mem_write_data    (mem_write_data),
    .mem_write_ready   (mem_write_ready)
  );

  always #5 clock = ~clock;

  // Backing memory: preloaded with an address-derived pattern, updated by accepted writes.
  assign mem_data = mem_model[mem_address[9:2]];

  always @(posedge clock) begin
    if (reset_n && mem_write_enable && mem_write_ready) begin
      mem_model[mem_address[9:2]] <= mem_write_data;
      mem_writes <= mem_writes + 1;
    end
  end

  function automatic regval_t pattern(input regval_t addr);
    return 32'hC0DE_0000 | addr;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic check_word(input string name, input regval_t actual, input regval_t expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    cpu_read_enable  = v.rd;
    cpu_write_enable = v.wr;
    cpu_address      = v.addr;
    cpu_write_data   = v.wdata;
  endtask

  task automatic check_output(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    check_bit({tag, "_read_valid"}, cpu_read_valid, v.exp_valid);
    check_word({tag, "_read_data"}, cpu_read_data, v.exp_data);
    check_bit({tag, "_stall"}, cpu_stall, v.exp_stall);
    check_bit({tag, "_mem_addr_en"}, mem_address_enable, v.exp_mem_en);
    check_bit({tag, "_mem_wen"}, mem_write_enable, v.exp_wen);
  endtask

  // Holds a read at addr through a miss and refill; gap idle beats precede each data beat,
  // and invalidate is pulsed on beat inv_beat (negative for none).
  task automatic read_miss(input regval_t addr, input int gap, input int inv_beat,
                           input regval_t exp_data);
    regval_t base;
    int      stalls;
    base             = {addr[31:4], 4'h0};
    cpu_read_enable  = 1'b1;
    cpu_write_enable = 1'b0;
    cpu_address      = addr;
    mem_data_valid   = 1'b0;
    #1;
    check_bit("miss_req_stall", cpu_stall, 1'b1);
    check_bit("miss_req_valid", cpu_read_valid, 1'b0);
    stalls = cpu_stall ? 1 : 0;
    tick();
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        mem_data_valid = 1'b0;
        #1;
        check_word("fill_addr_hold", mem_address, base + regval_t'(4 * b));
        check_bit("fill_en_hold", mem_address_enable, 1'b1);
        stalls += cpu_stall ? 1 : 0;
        tick();
      end
      mem_data_valid = 1'b1;
      invalidate     = (b == inv_beat);
      #1;
      check_word("fill_addr", mem_address, base + regval_t'(4 * b));
      check_bit("fill_en", mem_address_enable, 1'b1);
      stalls += cpu_stall ? 1 : 0;
      tick();
      mem_data_valid = 1'b0;
      invalidate     = 1'b0;
    end
    #1;
    if (inv_beat >= 0) begin
      check_bit("refetch_miss_stall", cpu_stall, 1'b1);
      check_bit("refetch_miss_valid", cpu_read_valid, 1'b0);
    end else begin
      check_word("stall_cycles", regval_t'(stalls), regval_t'(1 + 4 * (gap + 1)));
      check_bit("post_fill_valid", cpu_read_valid, 1'b1);
      check_word("post_fill_data", cpu_read_data, exp_data);
      check_bit("post_fill_stall", cpu_stall, 1'b0);
      check_bit("post_fill_mem_en", mem_address_enable, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int writes_before;

    for (int i = 0; i < 256; i++) mem_model[i] = pattern(regval_t'(i * 4));

    vecs[0] = '{1'b1, 1'b0, 32'h108, 32'h0,         1'b1, 32'hC0DE_0108, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,         1'b1, 32'hC0DE_0100, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h10E, 32'h0,         1'b1, 32'hC0DE_010C, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h108, 32'h1234_5678, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 32'h108, 32'h0,         1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h104, 32'h0,         1'b1, 32'hC0DE_0104, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h104, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b0};

    // Outputs must be forced low while in reset, even with a request present.
    reset_n          = 1'b0;
    cpu_read_enable  = 1'b0;
    cpu_write_enable = 1'b1;
    cpu_address      = 32'h104;
    cpu_write_data   = 32'h5555_AAAA;
    invalidate       = 1'b0;
    mem_data_valid   = 1'b0;
    mem_write_ready  = 1'b1;
    #2;
    check_bit("reset_wen", mem_write_enable, 1'b0);
    check_bit("reset_stall", cpu_stall, 1'b0);
    check_bit("reset_mem_en", mem_address_enable, 1'b0);
    check_word("reset_mem_addr", mem_address, 32'h0);
    tick();
    tick();
    cpu_write_enable = 1'b0;
    reset_n          = 1'b1;
    tick();

    $display("[TB] cold read miss");
    read_miss(32'h104, 0, -1, 32'hC0DE_0104);
    tick();

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output(i, vecs[i]);
      tick();
    end

    $display("[TB] conflict misses");
    read_miss(32'h140, 0, -1, 32'hC0DE_0140);
    tick();
    read_miss(32'h100, 0, -1, 32'hC0DE_0100);
    tick();

    $display("[TB] write-through with delayed ready");
    writes_before    = mem_writes;
    cpu_read_enable  = 1'b0;
    cpu_write_enable = 1'b1;
    cpu_address      = 32'h104;
    cpu_write_data   = 32'hDEAD_BEEF;
    mem_write_ready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_bit("wr_wait_stall", cpu_stall, 1'b1);
      check_bit("wr_wait_wen", mem_write_enable, 1'b1);
      check_word("wr_wait_addr", mem_address, 32'h104);
      tick();
    end
    mem_write_ready = 1'b1;
    #1;
    check_bit("wr_accept_stall", cpu_stall, 1'b0);
    check_word("wr_accept_data", mem_write_data, 32'hDEAD_BEEF);
    tick();
    cpu_write_enable = 1'b0;
    check_word("wr_count", regval_t'(mem_writes - writes_before), 32'd1);
    cpu_read_enable = 1'b1;
    #1;
    check_bit("wr_readback_valid", cpu_read_valid, 1'b1);
    check_word("wr_readback_data", cpu_read_data, 32'hDEAD_BEEF);
    check_bit("wr_readback_mem_en", mem_address_enable, 1'b0);
    tick();

    $display("[TB] write to uncached line");
    writes_before    = mem_writes;
    cpu_read_enable  = 1'b0;
    cpu_write_enable = 1'b1;
    cpu_address      = 32'h300;
    cpu_write_data   = 32'h0BAD_F00D;
    #1;
    check_bit("uncached_wr_stall", cpu_stall, 1'b0);
    check_bit("uncached_wr_mem_en", mem_address_enable, 1'b0);
    tick();
    cpu_write_enable = 1'b0;
    #1;
    check_bit("uncached_wr_no_fill", mem_address_enable, 1'b0);
    check_word("uncached_wr_count", regval_t'(mem_writes - writes_before), 32'd1);
    read_miss(32'h300, 0, -1, 32'h0BAD_F00D);
    tick();

    $display("[TB] invalidate in idle");
    cpu_read_enable = 1'b1;
    cpu_address     = 32'h308;
    invalidate      = 1'b1;
    #1;
    check_bit("inv_hit_valid", cpu_read_valid, 1'b1);
    check_word("inv_hit_data", cpu_read_data, 32'hC0DE_0308);
    tick();
    invalidate = 1'b0;
    read_miss(32'h308, 0, -1, 32'hC0DE_0308);
    tick();

    $display("[TB] invalidate during fill");
    read_miss(32'h104, 0, 2, 32'h0);
    read_miss(32'h104, 0, -1, 32'hDEAD_BEEF);
    tick();

    $display("[TB] refill with beat gaps");
    read_miss(32'h254, 2, -1, 32'hC0DE_0254);
    tick();

    $display("[TB] reset during fill");
    cpu_read_enable = 1'b1;
    cpu_address     = 32'h344;
    tick();
    mem_data_valid = 1'b1;
    tick();
    tick();
    mem_data_valid = 1'b0;
    reset_n        = 1'b0;
    #1;
    check_bit("rst_fill_mem_en", mem_address_enable, 1'b0);
    check_bit("rst_fill_stall", cpu_stall, 1'b0);
    check_word("rst_fill_addr", mem_address, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    read_miss(32'h344, 0, -1, 32'hC0DE_0344);
    tick();
    cpu_read_enable = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
